// File: rtl/vec_cmd_imm_queue.sv
// Command/immediate queue pair feeding the vector sequencer.
// Commands that need an immediate are issued together with the oldest queued immediate.

// Generic ring-buffer FIFO. The write is qualified internally by push_rdy.
// Latency: a push is visible at head_dat and count one cycle after its edge.
// Backpressure: push_rdy = (count != DEPTH); the caller must only pop when count != 0.
module vec_cmd_imm_queue_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  output logic                       push_rdy,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop_fire;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign push_rdy  = (count != CW'(DEPTH));
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop && (count != '0);
  assign head_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// Dual-queue responder: cmdq + ximm1q draining in order into one output register.
// Latency: push at edge N into an empty block -> io_deq_valid after edge N+1.
// Backpressure: per-queue ready from registered counts; output holds while io_deq_ready=0.
module vec_cmd_imm_queue #(
  parameter int CMD_W      = 16,
  parameter int IMM_W      = 32,
  parameter int CMDQ_DEPTH = 4,
  parameter int XIMM_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          io_enq_cmdq_valid,
  input  logic [CMD_W-1:0]              io_enq_cmdq_bits,
  output logic                          io_enq_cmdq_ready,
  input  logic                          io_enq_ximm1q_valid,
  input  logic [IMM_W-1:0]              io_enq_ximm1q_bits,
  output logic                          io_enq_ximm1q_ready,
  output logic                          io_deq_valid,
  input  logic                          io_deq_ready,
  output logic [CMD_W-1:0]              io_deq_cmd,
  output logic [IMM_W-1:0]              io_deq_imm,
  output logic [$clog2(CMDQ_DEPTH):0]   io_cmdq_count,
  output logic [$clog2(XIMM_DEPTH):0]   io_ximm1q_count
);

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [IMM_W-1:0] imm;
  } deq_ent_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_IMM = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CMD_W-1:0] cmd_head;
  logic [IMM_W-1:0] imm_head;
  logic             cmd_pop;
  logic             imm_pop;
  logic             load;
  logic             eval;
  deq_ent_t         ld_ent;
  deq_ent_t         out_q;

  vec_cmd_imm_queue_fifo #(
    .W     (CMD_W),
    .DEPTH (CMDQ_DEPTH)
  ) u_cmdq (
    .clk      (clk),
    .reset    (reset),
    .push_vld (io_enq_cmdq_valid),
    .push_dat (io_enq_cmdq_bits),
    .push_rdy (io_enq_cmdq_ready),
    .pop      (cmd_pop),
    .head_dat (cmd_head),
    .count    (io_cmdq_count)
  );

  vec_cmd_imm_queue_fifo #(
    .W     (IMM_W),
    .DEPTH (XIMM_DEPTH)
  ) u_ximm1q (
    .clk      (clk),
    .reset    (reset),
    .push_vld (io_enq_ximm1q_valid),
    .push_dat (io_enq_ximm1q_bits),
    .push_rdy (io_enq_ximm1q_ready),
    .pop      (imm_pop),
    .head_dat (imm_head),
    .count    (io_ximm1q_count)
  );

  // The load rule runs whenever the output register is free or being drained this cycle.
  assign eval = (state != ST_FULL) || io_deq_ready;

  always_comb begin
    state_nxt  = state;
    cmd_pop    = 1'b0;
    imm_pop    = 1'b0;
    load       = 1'b0;
    ld_ent.cmd = cmd_head;
    ld_ent.imm = '0;
    if (eval) begin
      if (io_cmdq_count == '0) begin
        state_nxt = ST_IDLE;
      end else if (!cmd_head[CMD_W-1]) begin
        cmd_pop   = 1'b1;
        load      = 1'b1;
        state_nxt = ST_FULL;
      end else if (io_ximm1q_count != '0) begin
        cmd_pop    = 1'b1;
        imm_pop    = 1'b1;
        load       = 1'b1;
        ld_ent.imm = imm_head;
        state_nxt  = ST_FULL;
      end else begin
        state_nxt = ST_WAIT_IMM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_q <= ld_ent;
      end
    end
  end

  // Payload keeps its last value after draining; only valid drops.
  assign io_deq_valid = (state == ST_FULL);
  assign io_deq_cmd   = out_q.cmd;
  assign io_deq_imm   = out_q.imm;

endmodule

// File: tb/tb_vec_cmd_imm_queue.sv
// Directed bench for vec_cmd_imm_queue with a pairing-model scoreboard on the deq port.
module tb_vec_cmd_imm_queue;

  logic        clk;
  logic        reset;
  logic        io_enq_cmdq_valid;
  logic [15:0] io_enq_cmdq_bits;
  logic        io_enq_cmdq_ready;
  logic        io_enq_ximm1q_valid;
  logic [31:0] io_enq_ximm1q_bits;
  logic        io_enq_ximm1q_ready;
  logic        io_deq_valid;
  logic        io_deq_ready;
  logic [15:0] io_deq_cmd;
  logic [31:0] io_deq_imm;
  logic [2:0]  io_cmdq_count;
  logic [2:0]  io_ximm1q_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mcq[$];
  logic [31:0] miq[$];
  logic [47:0] exq[$];

  vec_cmd_imm_queue #(
    .CMD_W      (16),
    .IMM_W      (32),
    .CMDQ_DEPTH (4),
    .XIMM_DEPTH (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .io_enq_cmdq_valid   (io_enq_cmdq_valid),
    .io_enq_cmdq_bits    (io_enq_cmdq_bits),
    .io_enq_cmdq_ready   (io_enq_cmdq_ready),
    .io_enq_ximm1q_valid (io_enq_ximm1q_valid),
    .io_enq_ximm1q_bits  (io_enq_ximm1q_bits),
    .io_enq_ximm1q_ready (io_enq_ximm1q_ready),
    .io_deq_valid        (io_deq_valid),
    .io_deq_ready        (io_deq_ready),
    .io_deq_cmd          (io_deq_cmd),
    .io_deq_imm          (io_deq_imm),
    .io_cmdq_count       (io_cmdq_count),
    .io_ximm1q_count     (io_ximm1q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pairing: each flagged command takes the oldest unclaimed immediate.
  task automatic resolve();
    logic [15:0] h;
    while (mcq.size() > 0) begin
      h = mcq[0];
      if (h[15] && miq.size() == 0) break;
      if (h[15]) begin
        exq.push_back({h, miq[0]});
        void'(miq.pop_front());
      end else begin
        exq.push_back({h, 32'h0});
      end
      void'(mcq.pop_front());
    end
  endtask

  task automatic cyc(input bit cv, input logic [15:0] c, input bit iv, input logic [31:0] im,
                     input bit dr, input bit cacc = 1'b1, input bit iacc = 1'b1);
    io_enq_cmdq_valid   = cv;
    io_enq_cmdq_bits    = c;
    io_enq_ximm1q_valid = iv;
    io_enq_ximm1q_bits  = im;
    io_deq_ready        = dr;
    @(negedge clk);
    if (cv) chk("cmdq_ready", 64'(io_enq_cmdq_ready), 64'(cacc));
    if (iv) chk("ximm1q_ready", 64'(io_enq_ximm1q_ready), 64'(iacc));
    @(posedge clk);
    #1;
    io_enq_cmdq_valid   = 1'b0;
    io_enq_ximm1q_valid = 1'b0;
    if (cv && cacc) mcq.push_back(c);
    if (iv && iacc) miq.push_back(im);
    resolve();
  endtask

  // Every accepted output beat is checked against the model's next expected entry.
  always @(negedge clk) begin
    if (reset && io_deq_valid && io_deq_ready) begin
      chk("sb_has_entry", 64'(exq.size() != 0), 64'd1);
      if (exq.size() != 0) begin
        chk("deq_entry", 64'({io_deq_cmd, io_deq_imm}), 64'(exq[0]));
        void'(exq.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset               = 1'b0;
    io_enq_cmdq_valid   = 1'b0;
    io_enq_cmdq_bits    = '0;
    io_enq_ximm1q_valid = 1'b0;
    io_enq_ximm1q_bits  = '0;
    io_deq_ready        = 1'b0;
    #2;
    chk("rst_valid", 64'(io_deq_valid), 64'd0);
    chk("rst_cmd", 64'(io_deq_cmd), 64'd0);
    chk("rst_imm", 64'(io_deq_imm), 64'd0);
    chk("rst_cmdq_count", 64'(io_cmdq_count), 64'd0);
    chk("rst_ximm_count", 64'(io_ximm1q_count), 64'd0);
    chk("rst_cmdq_ready", 64'(io_enq_cmdq_ready), 64'd1);
    chk("rst_ximm_ready", 64'(io_enq_ximm1q_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Command without immediate
    cyc(1, 16'h0012, 0, 0, 0);
    chk("t1_latency_valid0", 64'(io_deq_valid), 64'd0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_valid", 64'(io_deq_valid), 64'd1);
    chk("t1_cmd", 64'(io_deq_cmd), 64'h0012);
    chk("t1_imm", 64'(io_deq_imm), 64'd0);
    chk("t1_cmdq_count", 64'(io_cmdq_count), 64'd0);
    cyc(0, 0, 0, 0, 1);
    chk("t1_valid_drop", 64'(io_deq_valid), 64'd0);
    chk("t1_cmd_hold", 64'(io_deq_cmd), 64'h0012);
    chk("t1_cmdq_count_end", 64'(io_cmdq_count), 64'd0);

    // Late immediate
    cyc(1, 16'h8003, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t2_wait_valid", 64'(io_deq_valid), 64'd0);
    end
    chk("t2_wait_cmdq_count", 64'(io_cmdq_count), 64'd1);
    cyc(0, 0, 1, 32'hDEADBEEF, 0);
    chk("t2_imm_valid0", 64'(io_deq_valid), 64'd0);
    chk("t2_ximm_count", 64'(io_ximm1q_count), 64'd1);
    cyc(0, 0, 0, 0, 0);
    chk("t2_valid", 64'(io_deq_valid), 64'd1);
    chk("t2_cmd", 64'(io_deq_cmd), 64'h8003);
    chk("t2_imm", 64'(io_deq_imm), 64'hDEADBEEF);
    chk("t2_cmdq_count", 64'(io_cmdq_count), 64'd0);
    chk("t2_ximm_count0", 64'(io_ximm1q_count), 64'd0);
    cyc(0, 0, 0, 0, 1);

    // Full cmdq
    for (int i = 1; i <= 4; i++) cyc(1, 16'(16'h0100 + i), 0, 0, 0);
    chk("t3_count3", 64'(io_cmdq_count), 64'd3);
    chk("t3_valid", 64'(io_deq_valid), 64'd1);
    chk("t3_cmd_head", 64'(io_deq_cmd), 64'h0101);
    cyc(1, 16'h0105, 0, 0, 0);
    chk("t3_count4", 64'(io_cmdq_count), 64'd4);
    chk("t3_full_ready", 64'(io_enq_cmdq_ready), 64'd0);
    cyc(1, 16'h0106, 0, 0, 0, 1'b0);
    chk("t3_reject_count", 64'(io_cmdq_count), 64'd4);
    chk("t3_hold_cmd", 64'(io_deq_cmd), 64'h0101);
    cyc(1, 16'h0107, 0, 0, 1, 1'b0);
    chk("t3_deq_push_count", 64'(io_cmdq_count), 64'd3);
    chk("t3_next_cmd", 64'(io_deq_cmd), 64'h0102);
    repeat (5) cyc(0, 0, 0, 0, 1);
    chk("t3_drained_valid", 64'(io_deq_valid), 64'd0);
    chk("t3_drained_count", 64'(io_cmdq_count), 64'd0);

    // Back-to-back drain A/0, B/I, C/0
    cyc(1, 16'h0A00, 1, 32'h1234_5678, 0);
    cyc(1, 16'h8B00, 0, 0, 0);
    cyc(1, 16'h0C00, 0, 0, 0);
    chk("t4_head_cmd", 64'(io_deq_cmd), 64'h0A00);
    cyc(0, 0, 0, 0, 1);
    chk("t4_no_bubble1", 64'(io_deq_valid), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t4_no_bubble2", 64'(io_deq_valid), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t4_end_valid", 64'(io_deq_valid), 64'd0);
    chk("t4_cmdq_count", 64'(io_cmdq_count), 64'd0);
    chk("t4_ximm_count", 64'(io_ximm1q_count), 64'd0);

    // Wrap-around: 10 entries through depth-4 queues at full rate
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) cyc(1, 16'(16'h8200 + i), 1, 32'(32'h1000_0000 + i), 1);
      else            cyc(1, 16'(16'h0200 + i), 0, 0, 1);
    end
    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("t5_valid", 64'(io_deq_valid), 64'd0);
    chk("t5_cmdq_count", 64'(io_cmdq_count), 64'd0);
    chk("t5_ximm_count", 64'(io_ximm1q_count), 64'd0);
    chk("t5_sb_empty", 64'(exq.size()), 64'd0);

    // Immediate with no flagged command just stays queued
    cyc(0, 0, 1, 32'h0000_0055, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    chk("t6_ximm_count", 64'(io_ximm1q_count), 64'd1);
    chk("t6_valid", 64'(io_deq_valid), 64'd0);
    cyc(1, 16'h8077, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t6_cmd", 64'(io_deq_cmd), 64'h8077);
    chk("t6_imm", 64'(io_deq_imm), 64'h55);
    cyc(0, 0, 0, 0, 1);

    // Reset mid-stream
    for (int i = 1; i <= 4; i++) cyc(1, 16'(16'h0300 + i), 0, 0, 0);
    chk("t7_pre_count", 64'(io_cmdq_count), 64'd3);
    chk("t7_pre_valid", 64'(io_deq_valid), 64'd1);
    #3;
    reset = 1'b0;
    mcq.delete();
    miq.delete();
    exq.delete();
    #1;
    chk("t7_rst_valid", 64'(io_deq_valid), 64'd0);
    chk("t7_rst_cmdq_count", 64'(io_cmdq_count), 64'd0);
    chk("t7_rst_ximm_count", 64'(io_ximm1q_count), 64'd0);
    #2;
    reset = 1'b1;
    chk("t7_cmdq_ready", 64'(io_enq_cmdq_ready), 64'd1);
    chk("t7_ximm_ready", 64'(io_enq_ximm1q_ready), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("t7_no_issue", 64'(io_deq_valid), 64'd0);
    end
    chk("final_sb_empty", 64'(exq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_cmd_imm_queue.md
Name: vec_cmd_imm_queue

Overview:
- Queue-side responder for the decoder's `enq_cmdq` / `enq_ximm1q` signals.
- Holds two FIFOs: a command queue (cmdq) and an immediate queue (ximm1q).
- Exports per-queue ready signals; the decoder's replay logic uses these so it issues only when every queue it targets is ready.
- Drains in order to the vector sequencer, pairing each command that needs an immediate with the head of ximm1q.

Parameters:
- CMD_W, 16, command width; bit CMD_W-1 is the needs-immediate flag.
- IMM_W, 32, immediate width.
- CMDQ_DEPTH, 4, cmdq entries (power of 2, at least 2).
- XIMM_DEPTH, 4, ximm1q entries (power of 2, at least 2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- io_enq_cmdq_valid  in  1  push command.
- io_enq_cmdq_bits  in  CMD_W  command.
- io_enq_cmdq_ready  out  1  cmdq not full.
- io_enq_ximm1q_valid  in  1  push immediate.
- io_enq_ximm1q_bits  in  IMM_W  immediate.
- io_enq_ximm1q_ready  out  1  ximm1q not full.
- io_deq_valid  out  1  output register holds an entry.
- io_deq_ready  in  1  sequencer accepts.
- io_deq_cmd  out  CMD_W  issued command.
- io_deq_imm  out  IMM_W  paired immediate; 0 when no immediate is needed.
- io_cmdq_count  out  log2(CMDQ_DEPTH)+1  cmdq occupancy.
- io_ximm1q_count  out  log2(XIMM_DEPTH)+1  ximm1q occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and counts go to 0; FSM goes to IDLE.
  - io_deq_valid=0, io_deq_cmd=0, io_deq_imm=0.
  - io_enq_*_ready=1 as soon as reset is released. Both ready signals are 1 during reset as well, since they are derived from count.
  - Reset mid-operation discards all queued and held entries.
- Enqueue:
  - A push happens when valid && ready at the clk edge.
  - ready = (count != DEPTH). It is derived from registered count only and never from io_deq_ready or the enq valids.
  - When full, a push is not accepted even if a pop happens in the same cycle.
  - Pushes to both queues in the same cycle are independent.
- FIFO pointers wrap modulo DEPTH. count is updated +1 on push, -1 on pop, unchanged on push+pop.
- FSM states:
  - IDLE: output register empty or being emptied.
  - WAIT_IMM: cmdq head has the flag set and ximm1q is empty.
  - FULL: output register valid.
- Load rule, evaluated in IDLE, in WAIT_IMM, and in FULL when io_deq_ready=1:
  - cmdq empty → no load; next state IDLE.
  - Head flag=0 → pop cmdq; load cmd with imm=0; next state FULL.
  - Head flag=1 and ximm1q count>0 → pop both queues in the same cycle; load cmd and imm; next state FULL.
  - Head flag=1 and ximm1q empty → no pop; next state WAIT_IMM.
- In FULL with io_deq_ready=0: hold the output stable, do not pop, and keep io_deq_cmd/io_deq_imm unchanged.
- On the FULL→IDLE transition with no load, io_deq_cmd and io_deq_imm keep their last value and io_deq_valid=0.
- Timing:
  - Latency: a push at edge N into an empty block gives io_deq_valid=1 in the cycle after edge N+1.
  - Throughput is 1 entry per cycle while io_deq_ready is held at 1.
- Ordering:
  - Strict FIFO order in each queue.
  - Immediates are consumed only by flagged commands, in order.
  - A flagged command never issues without its immediate.
- Not a protocol error: an immediate pushed with no flagged command pending just stays queued.

Test Plan:
- Reset check: assert reset=0 mid-stream with 3 entries in cmdq and io_deq_valid=1 → the same cycle shows io_deq_valid=0 and counts=0; after release, both ready=1 and nothing is issued.
- Command without immediate: push cmd 0x0012 at edge 0 → io_deq_valid=1 after edge 1 with io_deq_cmd=0x0012 and io_deq_imm=0; pulse io_deq_ready → valid drops and io_cmdq_count=0.
- Late immediate: push cmd 0x8003, wait 5 cycles, then push imm 0xDEADBEEF → FSM holds WAIT_IMM with valid=0 throughout; 2 cycles after the immediate push, cmd=0x8003, imm=0xDEADBEEF, valid=1, and both counts=0.
- Full cmdq: push 4 commands with io_deq_ready=0 → io_cmdq_count=3 (the first command sits in the output register); a 5th push is taken (count 4), after which io_enq_cmdq_ready=0 and a 6th push is rejected; then one deq plus a push in the same cycle → the push is rejected and count ends at 3.
- Back-to-back drain: cmds A (flag 0), B (flag 1), C (flag 0) plus imm I queued, io_deq_ready=1 → issue on consecutive cycles as A/0, B/I, C/0, with no bubbles.
- Wrap-around: push and pop 10 commands through the depth-4 cmdq → output order is preserved across two pointer wraps, and counts return to 0.
